ping_pong_fpga_ctrl: RTL and testbench

- Board-level controller for the parameterized ping-pong counter.
- Turns raw board inputs into clean counter controls:
  - divides the system clock into a one-cycle count-enable tick;
  - debounces and one-pulses the flip button;
  - validates max/min switch settings and shadows them, applying a new setting only on a tick boundary;
  - time-multiplexes the counter value and direction onto the 4-digit 7-segment display.
- Sits between board I/O and the counter datapath.

---
 rtl/ping_pong_fpga_ctrl.sv | 170 +++++++++++++++++
 tb/tb_ping_pong_fpga_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ping_pong_fpga_ctrl.sv
// Board-level controller for the ping-pong counter: count-enable tick, flip debounce,
// shadowed min/max configuration and 4-digit 7-segment display scan.
module ping_pong_fpga_ctrl #(
  parameter int TICK_DIV = 25_000_000,
  parameter int DB_LEN   = 4,
  parameter int SCAN_DIV = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_sw,
  input  logic       flip_btn,
  input  logic [3:0] max_sw,
  input  logic [3:0] min_sw,
  input  logic [3:0] cnt,
  input  logic       dir,
  output logic       cnt_en,
  output logic       flip_pulse,
  output logic [3:0] max_cfg,
  output logic [3:0] min_cfg,
  output logic       cfg_ok,
  output logic [3:0] AN,
  output logic [6:0] segs
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] PEND = 1'b1;

  localparam logic [6:0] GLYPH_UP   = 7'b0011100;
  localparam logic [6:0] GLYPH_DOWN = 7'b0100011;

  logic [TICK_W-1:0] tick_cnt;
  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        idx;
  logic [DB_LEN-1:0] db_sr;
  logic              db;
  logic              db_next;
  logic [0:0]        state;
  logic              legal;
  logic              same;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Digits 0 and 1 carry the direction glyph, 2 the ones and 3 the tens of cnt.
  function automatic logic [6:0] digit_segs(input logic [1:0] i, input logic [3:0] v,
                                             input logic up);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = (v >= 4'd10) ? 4'd1 : 4'd0;
    ones = (v >= 4'd10) ? v - 4'd10 : v;
    case (i)
      2'd2:    digit_segs = seg7(ones);
      2'd3:    digit_segs = seg7(tens);
      default: digit_segs = up ? GLYPH_UP : GLYPH_DOWN;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
      cnt_en   <= 1'b0;
    end else if (enable_sw) begin
      if (tick_cnt == TICK_LAST) begin
        tick_cnt <= '0;
        cnt_en   <= 1'b1;
      end else begin
        tick_cnt <= tick_cnt + TICK_W'(1);
        cnt_en   <= 1'b0;
      end
    end else begin
      cnt_en <= 1'b0;
    end
  end

  // db only changes on a unanimous window, so mixed samples hold the last decision.
  always_comb begin
    db_next = db;
    if (&db_sr)
      db_next = 1'b1;
    else if (~|db_sr)
      db_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      db_sr      <= '0;
      db         <= 1'b0;
      flip_pulse <= 1'b0;
    end else begin
      db_sr      <= DB_LEN'({db_sr, flip_btn});
      db         <= db_next;
      flip_pulse <= db_next & ~db;
    end
  end

  assign legal = (max_sw > min_sw);
  assign same  = (max_sw == max_cfg) && (min_sw == min_cfg);

  // A PEND load on a cnt_en edge lets that step finish with the old range.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      max_cfg <= 4'hf;
      min_cfg <= 4'h0;
      cfg_ok  <= 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (same) begin
            cfg_ok <= 1'b1;
          end else if (!legal) begin
            cfg_ok <= 1'b0;
          end else begin
            state  <= PEND;
            cfg_ok <= 1'b1;
          end
        end
        PEND: begin
          if (!legal) begin
            state  <= RUN;
            cfg_ok <= 1'b0;
          end else if (cnt_en || !enable_sw) begin
            max_cfg <= max_sw;
            min_cfg <= min_sw;
            state   <= RUN;
            cfg_ok  <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= 2'd0;
      AN       <= 4'b1111;
      segs     <= 7'b1111111;
    end else begin
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        idx      <= idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
      end
      AN   <= ~(4'b0001 << idx);
      segs <= digit_segs(idx, cnt, dir);
    end
  end

endmodule

// File: tb/tb_ping_pong_fpga_ctrl.sv
// Directed bench for ping_pong_fpga_ctrl with TICK_DIV=4, DB_LEN=3, SCAN_DIV=2.
module tb_ping_pong_fpga_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable_sw;
  logic       flip_btn;
  logic [3:0] max_sw;
  logic [3:0] min_sw;
  logic [3:0] cnt;
  logic       dir;
  logic       cnt_en;
  logic       flip_pulse;
  logic [3:0] max_cfg;
  logic [3:0] min_cfg;
  logic       cfg_ok;
  logic [3:0] AN;
  logic [6:0] segs;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ping_pong_fpga_ctrl #(.TICK_DIV(4), .DB_LEN(3), .SCAN_DIV(2)) dut (
    .clk(clk), .rst(rst), .enable_sw(enable_sw), .flip_btn(flip_btn),
    .max_sw(max_sw), .min_sw(min_sw), .cnt(cnt), .dir(dir),
    .cnt_en(cnt_en), .flip_pulse(flip_pulse), .max_cfg(max_cfg), .min_cfg(min_cfg),
    .cfg_ok(cfg_ok), .AN(AN), .segs(segs)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      step(1);
      n++;
    end while (cnt_en !== 1'b1 && n < 20);
    chk("tick_seen", cnt_en, 1);
  endtask

  task automatic sync_scan();
    int n;
    n = 0;
    while (AN !== 4'b0111 && n < 20) begin step(1); n++; end
    while (AN === 4'b0111 && n < 40) begin step(1); n++; end
    chk("scan_sync", AN, 4'b1110);
  endtask

  task automatic scan_check(input logic [6:0] glyph);
    logic [3:0] an_e [4];
    logic [6:0] sg_e [4];
    an_e = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    sg_e = '{glyph, glyph, 7'b0100100, 7'b1111001};
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("scan_an_%0d", i), AN, an_e[i/2]);
      chk($sformatf("scan_seg_%0d", i), segs, sg_e[i/2]);
      step(1);
    end
  endtask

  initial begin
    rst = 1'b1; enable_sw = 1'b1; flip_btn = 1'b0;
    max_sw = 4'd15; min_sw = 4'd0; cnt = 4'd0; dir = 1'b1;
    step(2);
    chk("rst_cnt_en", cnt_en, 0);
    chk("rst_flip", flip_pulse, 0);
    chk("rst_max", max_cfg, 15);
    chk("rst_min", min_cfg, 0);
    chk("rst_cfg_ok", cfg_ok, 1);
    chk("rst_an", AN, 4'b1111);
    chk("rst_segs", segs, 7'b1111111);

    // Tick cadence, then pause and resume
    rst = 1'b0;
    step(1);
    chk("first_an", AN, 4'b1110);
    chk("first_segs", segs, 7'b0011100);
    chk("tick_e1", cnt_en, 0);
    for (int k = 2; k <= 12; k++) begin
      step(1);
      chk($sformatf("tick_e%0d", k), cnt_en, (k % 4 == 0) ? 1 : 0);
    end
    step(2);
    enable_sw = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      chk("tick_paused", cnt_en, 0);
    end
    enable_sw = 1'b1;
    step(1);
    chk("tick_resume_3", cnt_en, 0);
    step(1);
    chk("tick_resume_wrap", cnt_en, 1);

    // Flip debounce
    flip_btn = 1'b1;
    step(2);
    flip_btn = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step(1);
      chk("flip_short", flip_pulse, 0);
    end
    flip_btn = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      chk($sformatf("flip_hold_%0d", k), flip_pulse, (k == 4) ? 1 : 0);
    end
    flip_btn = 1'b0;
    step(1);
    flip_btn = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step(1);
      chk("flip_glitch", flip_pulse, 0);
    end
    flip_btn = 1'b0;
    step(5);

    // Legal config change waits for the tick
    wait_tick();
    step(1);
    max_sw = 4'd4;
    step(1);
    chk("cfg3_ok", cfg_ok, 1);
    chk("cfg3_hold_a", max_cfg, 15);
    step(1);
    chk("cfg3_hold_b", max_cfg, 15);
    step(1);
    chk("cfg3_tick", cnt_en, 1);
    chk("cfg3_hold_c", max_cfg, 15);
    step(1);
    chk("cfg3_max", max_cfg, 4);
    chk("cfg3_min", min_cfg, 0);
    chk("cfg3_ok2", cfg_ok, 1);

    // Illegal requests, then legal restore on tick and with enable low
    wait_tick();
    max_sw = 4'd2; min_sw = 4'd3;
    step(1);
    chk("ill_ok", cfg_ok, 0);
    chk("ill_max", max_cfg, 4);
    chk("ill_min", min_cfg, 0);
    step(1);
    chk("ill_max_b", max_cfg, 4);
    max_sw = 4'd2; min_sw = 4'd2;
    step(1);
    chk("eq_ok", cfg_ok, 0);
    max_sw = 4'd3; min_sw = 4'd1;
    step(1);
    chk("fix_ok", cfg_ok, 1);
    chk("fix_tick", cnt_en, 1);
    chk("fix_hold", max_cfg, 4);
    step(1);
    chk("fix_max", max_cfg, 3);
    chk("fix_min", min_cfg, 1);
    enable_sw = 1'b0;
    max_sw = 4'd7; min_sw = 4'd2;
    step(1);
    chk("dis_hold", max_cfg, 3);
    step(1);
    chk("dis_max", max_cfg, 7);
    chk("dis_min", min_cfg, 2);
    chk("dis_ok", cfg_ok, 1);
    enable_sw = 1'b1;

    // Display scan
    cnt = 4'd12; dir = 1'b1;
    sync_scan();
    scan_check(7'b0011100);
    dir = 1'b0;
    sync_scan();
    scan_check(7'b0100011);

    // Reset while a config is pending
    wait_tick();
    max_sw = 4'd9; min_sw = 4'd5;
    step(1);
    rst = 1'b1;
    step(1);
    chk("mid_rst_max", max_cfg, 15);
    chk("mid_rst_min", min_cfg, 0);
    chk("mid_rst_ok", cfg_ok, 1);
    chk("mid_rst_an", AN, 4'b1111);
    chk("mid_rst_segs", segs, 7'b1111111);
    chk("mid_rst_cnt_en", cnt_en, 0);
    rst = 1'b0;
    step(1);
    chk("post_rst_an", AN, 4'b1110);
    step(2);
    chk("post_rst_hold", max_cfg, 15);
    step(1);
    chk("post_rst_tick", cnt_en, 1);
    chk("post_rst_hold_b", max_cfg, 15);
    step(1);
    chk("post_rst_max", max_cfg, 9);
    chk("post_rst_min", min_cfg, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
